dmem_arbiter: RTL
=================

Name: dmem_arbiter

Overview:
- Arbitrates the single-port 64x16 data memory between two requesters: the CPU load/store path and a debug/loader port driven from the top-level pins.
- Round-robin arbitration, plus a bounded burst lock for the debug port.
- Issues one memory access per cycle and returns read data one cycle later with a per-requester valid.
- Sits between mips_single_cycle and the data memory; the CPU stalls on `cpu_stall`.

Parameters:
- ADDR_W, 6, memory word-address width (64 words).
- DATA_W, 16, data width.
- LOCK_MAX, 8, maximum consecutive locked debug grants while the CPU is requesting.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- cpu_req  in  1  CPU access request; held with cmd stable until cpu_gnt.
- cpu_we  in  1  1 = write, 0 = read.
- cpu_addr  in  ADDR_W  CPU word address.
- cpu_wdata  in  DATA_W  CPU write data.
- cpu_gnt  out  1  CPU access issued this cycle.
- cpu_stall  out  1  cpu_req & ~cpu_gnt.
- cpu_rvalid  out  1  rdata belongs to the CPU read granted last cycle.
- dbg_req  in  1  debug access request.
- dbg_we  in  1  debug write enable.
- dbg_addr  in  ADDR_W  debug word address.
- dbg_wdata  in  DATA_W  debug write data.
- dbg_lock  in  1  request burst lock.
- dbg_gnt  out  1  debug access issued this cycle.
- dbg_rvalid  out  1  rdata belongs to the debug read granted last cycle.
- rdata  out  DATA_W  read data return; 0 when neither rvalid is high.
- mem_en  out  1  memory access strobe.
- mem_we  out  1  memory write enable.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  memory write data.
- mem_rdata  in  DATA_W  synchronous memory read data, valid 1 cycle after mem_en & ~mem_we.

Behaviour:
- Reset (async on rst_n low):
  - all outputs 0.
  - last_gnt = DBG, so the CPU wins the first tie.
  - lock_cnt = 0.
  - rvalid pipeline cleared; any read in flight is discarded and no rvalid follows reset release.
- Arbitration is combinational from registered state; at most one gnt per cycle.
  - Only one requester asserted: it is granted.
  - Both asserted, normal case: grant the requester not in last_gnt (round-robin).
  - Lock override: if dbg_lock & dbg_req & last_gnt==DBG & lock_cnt<LOCK_MAX, debug wins regardless of the CPU.
  - Starvation bound: when lock_cnt==LOCK_MAX and cpu_req=1, the CPU gets the grant. lock_cnt then clears.
  - lock_cnt increments on each debug grant while cpu_req=1 and dbg_lock=1. It saturates at LOCK_MAX and clears on any CPU grant or when dbg_lock=0.
  - last_gnt updates only on a grant cycle; idle cycles keep it.
- Memory command:
  - On a grant cycle: mem_en=1; mem_we/mem_addr/mem_wdata are muxed from the winner.
  - No grant: mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0.
- Read return:
  - A read granted in cycle N produces {cpu|dbg}_rvalid=1 and rdata=mem_rdata in cycle N+1, for exactly one cycle.
  - Writes produce no rvalid.
  - Back-to-back reads, alternating or not, give one rvalid per cycle with no bubbles.
- Write-then-read to the same address in consecutive cycles returns the new data; memory write-first behaviour is required.
- Handshake: the requester must hold req/we/addr/wdata until gnt. Dropping req before gnt is legal; nothing is issued. Changes during a non-granted cycle have no effect.
- Address width is exact; no out-of-range case exists inside this block.
- Throughput: 1 access/cycle total. A lone requester is granted every cycle it requests.

Test Plan:
- Reset release, CPU reads addr 2 (mem holds 0x9ABC): cpu_gnt same cycle, mem_en=1, mem_addr=2; next cycle cpu_rvalid=1, rdata=0x9ABC, dbg_rvalid=0.
- Both request continuously (CPU read addr 1, dbg write addr 5 = 0x00AA), dbg_lock=0: grants alternate CPU, DBG, CPU, DBG; cpu_stall high only on DBG cycles; mem[5]=0x00AA afterward.
- dbg_lock=1 with both requesting, LOCK_MAX=8: 8 consecutive dbg_gnt, then 1 cpu_gnt, then debug resumes; cpu_stall never exceeds 8 consecutive cycles.
- Debug writes 0x1357 to addr 10 in cycle N, CPU reads addr 10 in cycle N+1: cpu_rvalid in N+2 with rdata=0x1357.
- CPU read granted, rst_n asserted low in the following cycle: all outputs 0 immediately, no cpu_rvalid after release; first tie after release goes to the CPU.
- Idle cycles (no req): mem_en=0, rdata=0; last_gnt is preserved, so a subsequent tie goes to the requester not last granted.

Source files
------------

// File: rtl/dmem_arbiter.sv
// Two-requester arbiter for the single-port data memory: CPU load/store path vs debug/loader port.
// Round-robin with a bounded debug burst lock; read data returns one cycle after the grant.
//
// last_gnt | meaning
// CPU      | CPU owned the most recent granted cycle; a tie goes to debug
// DBG      | debug owned the most recent granted cycle (reset value); a tie goes to the CPU
module dmem_arbiter #(
    parameter int ADDR_W   = 6,
    parameter int DATA_W   = 16,
    parameter int LOCK_MAX = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_gnt,
    output logic              cpu_stall,
    output logic              cpu_rvalid,
    input  logic              dbg_req,
    input  logic              dbg_we,
    input  logic [ADDR_W-1:0] dbg_addr,
    input  logic [DATA_W-1:0] dbg_wdata,
    input  logic              dbg_lock,
    output logic              dbg_gnt,
    output logic              dbg_rvalid,
    output logic [DATA_W-1:0] rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int CNT_W = $clog2(LOCK_MAX + 1);
    localparam logic [CNT_W-1:0] LOCK_TOP = CNT_W'(LOCK_MAX);

    typedef enum logic {
        OWNER_CPU = 1'b0,
        OWNER_DBG = 1'b1
    } owner_t;

    owner_t           last_gnt, last_gnt_nxt;
    logic [CNT_W-1:0] lock_cnt, lock_cnt_nxt;
    logic             cpu_rd_q, dbg_rd_q;
    logic             grant_cpu, grant_dbg;
    logic             lock_hold, lock_expired;

    // Grants are gated by rst_n so every output is low for the whole reset window.
    always_comb begin
        grant_cpu    = 1'b0;
        grant_dbg    = 1'b0;
        lock_expired = cpu_req && (lock_cnt == LOCK_TOP);
        lock_hold    = dbg_lock && dbg_req && (last_gnt == OWNER_DBG) && (lock_cnt < LOCK_TOP);
        if (rst_n) begin
            if (cpu_req && dbg_req) begin
                if (lock_expired)
                    grant_cpu = 1'b1;
                else if (lock_hold)
                    grant_dbg = 1'b1;
                else if (last_gnt == OWNER_DBG)
                    grant_cpu = 1'b1;
                else
                    grant_dbg = 1'b1;
            end else if (cpu_req) begin
                grant_cpu = 1'b1;
            end else if (dbg_req) begin
                grant_dbg = 1'b1;
            end
        end
    end

    always_comb begin
        last_gnt_nxt = last_gnt;
        if (grant_cpu)
            last_gnt_nxt = OWNER_CPU;
        else if (grant_dbg)
            last_gnt_nxt = OWNER_DBG;

        lock_cnt_nxt = lock_cnt;
        if (!dbg_lock || grant_cpu)
            lock_cnt_nxt = '0;
        else if (grant_dbg && cpu_req && (lock_cnt != LOCK_TOP))
            lock_cnt_nxt = lock_cnt + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_gnt <= OWNER_DBG;
            lock_cnt <= '0;
            cpu_rd_q <= 1'b0;
            dbg_rd_q <= 1'b0;
        end else begin
            last_gnt <= last_gnt_nxt;
            lock_cnt <= lock_cnt_nxt;
            cpu_rd_q <= grant_cpu && !cpu_we;
            dbg_rd_q <= grant_dbg && !dbg_we;
        end
    end

    always_comb begin
        mem_en    = grant_cpu || grant_dbg;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (grant_cpu) begin
            mem_we    = cpu_we;
            mem_addr  = cpu_addr;
            mem_wdata = cpu_wdata;
        end else if (grant_dbg) begin
            mem_we    = dbg_we;
            mem_addr  = dbg_addr;
            mem_wdata = dbg_wdata;
        end
    end

    assign cpu_gnt    = grant_cpu;
    assign dbg_gnt    = grant_dbg;
    assign cpu_stall  = rst_n && cpu_req && !grant_cpu;
    assign cpu_rvalid = cpu_rd_q;
    assign dbg_rvalid = dbg_rd_q;
    assign rdata      = (cpu_rd_q || dbg_rd_q) ? mem_rdata : '0;

endmodule
